// File: rtl/h266_ref_pkg.sv
// Shared types and sizes for the affine MC reference-area RAM path.
// One area = REF_NUM_LINES lines of 16 x 8-bit pixels; two areas ping-pong.
package h266_ref_pkg;

   localparam int REF_LINE_W    = 128;
   localparam int REF_NUM_LINES = 384;
   localparam int REF_LADDR_W   = 9;

   typedef logic [REF_LINE_W-1:0] ref_line_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      WAIT_SWAP = 2'd2
   } ref_ld_state_t;

endpackage

// File: rtl/ref_ram_loader.sv
// Write-side feeder of the two-bank reference RAM: fills one bank from the line
// stream, then swaps banks with the reader once it has released the other one.
module ref_ram_loader
   import h266_ref_pkg::*;
#(
   parameter int LINE_W    = REF_LINE_W,
   parameter int NUM_LINES = REF_NUM_LINES,
   parameter int LADDR_W   = REF_LADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [LINE_W-1:0]  s_data,
   input  logic               s_last,
   output logic               ram_we,
   output logic               ram_bank,
   output logic [LADDR_W-1:0] ram_waddr,
   output logic [LINE_W-1:0]  ram_wdata,
   output logic               rd_bank,
   output logic               rd_valid,
   output logic               load_ref_ram,
   input  logic               rd_release,
   output logic               busy,
   output logic               err_len
);

   ref_ld_state_t      state_q;
   logic [LADDR_W-1:0] cnt_q;
   logic               fill_bank_q;
   logic               rd_bank_q;
   logic               rd_valid_q;
   logic               rd_free_q;
   logic               s_ready_q;
   logic               err_q;

   logic beat;
   logic at_end;
   logic swap;

   assign beat   = s_valid & s_ready_q;
   assign at_end = (cnt_q == LADDR_W'(NUM_LINES - 1));
   // Swap decision looks only at the registered release flag.
   assign swap   = (state_q == WAIT_SWAP) & rd_free_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         fill_bank_q <= 1'b0;
         rd_bank_q   <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_free_q   <= 1'b1;
         s_ready_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (rd_release && rd_valid_q) begin
            rd_free_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= FILL;
                  s_ready_q <= 1'b1;
                  cnt_q     <= '0;
               end
            end
            FILL: begin
               if (beat) begin
                  cnt_q <= cnt_q + LADDR_W'(1);
                  if (s_last && at_end) begin
                     state_q   <= WAIT_SWAP;
                     s_ready_q <= 1'b0;
                  end else if (s_last || at_end) begin
                     // Misplaced or missing s_last: the area is abandoned, no swap.
                     state_q   <= IDLE;
                     s_ready_q <= 1'b0;
                     err_q     <= 1'b1;
                  end
               end
            end
            WAIT_SWAP: begin
               if (swap) begin
                  rd_bank_q   <= fill_bank_q;
                  fill_bank_q <= ~fill_bank_q;
                  rd_valid_q  <= 1'b1;
                  rd_free_q   <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready      = s_ready_q;
   assign ram_we       = beat;
   assign ram_bank     = fill_bank_q;
   assign ram_waddr    = cnt_q;
   assign ram_wdata    = s_data;
   assign rd_bank      = rd_bank_q;
   assign rd_valid     = rd_valid_q;
   assign load_ref_ram = swap;
   assign busy         = (state_q != IDLE);
   assign err_len      = err_q;

endmodule

// File: tb/tb_ref_ram_loader.sv
// Randomized bench for ref_ram_loader against a bank-level ping-pong model.
module tb_ref_ram_loader;
   import h266_ref_pkg::*;

   localparam int N = REF_NUM_LINES;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic         s_last;
   logic         ram_we;
   logic         ram_bank;
   logic [8:0]   ram_waddr;
   logic [127:0] ram_wdata;
   logic         rd_bank;
   logic         rd_valid;
   logic         load_ref_ram;
   logic         rd_release;
   logic         busy;
   logic         err_len;

   int errors = 0;
   int checks = 0;

   // Model: which bank is being filled, which is readable, and whether the reader let go.
   bit m_fill, m_rd_bank, m_rd_valid, m_rd_free, m_wait;

   ref_ram_loader dut (
      .clk(clk), .rst(rst), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .ram_we(ram_we), .ram_bank(ram_bank), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .rd_bank(rd_bank), .rd_valid(rd_valid), .load_ref_ram(load_ref_ram),
      .rd_release(rd_release), .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_fill = 1'b0; m_rd_bank = 1'b1; m_rd_valid = 1'b0; m_rd_free = 1'b1; m_wait = 1'b0;
   endtask

   task automatic model_swap();
      if (m_wait && m_rd_free) begin
         m_rd_bank = m_fill; m_fill = ~m_fill; m_rd_valid = 1'b1; m_rd_free = 1'b0; m_wait = 1'b0;
      end
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
   endtask

   // mode 0: dense random, 1: every third cycle idle, 2: random gaps, 3: data = line index
   task automatic fill_area(input int n, input int last_at, input int mode,
                            input int start_at, input int rel_at, input bit chk_end);
      int beat = 0;
      int cyc = 0;
      logic v;
      logic [127:0] d;
      bit ok;
      while (beat < n && cyc < 4 * n + 16) begin
         @(posedge clk); #1;
         v = (mode == 1) ? ((cyc % 3) != 2) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         d = (mode == 3) ? 128'(beat) : {$urandom(), $urandom(), $urandom(), $urandom()};
         s_valid = v;
         s_data = d;
         s_last = v ? (beat == last_at) : 1'($urandom_range(0, 1));
         start = (cyc == start_at);
         rd_release = (cyc == rel_at);
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready cyc=%0d got s_ready=%b busy=%b want 1 1", cyc, s_ready, busy);
         end
         checks++;
         if (ram_we !== v || ram_waddr !== 9'(beat)) begin
            errors++;
            $display("FAIL fill_addr cyc=%0d got we=%b addr=%0d want we=%b addr=%0d",
                     cyc, ram_we, ram_waddr, v, beat);
         end
         if (v) begin
            checks++;
            if (ram_wdata !== d || ram_bank !== m_fill) begin
               errors++;
               $display("FAIL fill_data beat=%0d got bank=%b data=%h want bank=%b data=%h",
                        beat, ram_bank, ram_wdata, m_fill, d);
            end
            beat++;
         end
         if (rd_release && m_rd_valid) m_rd_free = 1'b1;
         cyc++;
      end
      if (beat < n) begin
         checks++; errors++;
         $display("FAIL fill_timeout got %0d beats want %0d", beat, n);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0; start = 1'b0; rd_release = 1'b0;
      if (chk_end) begin
         ok = (n == N) && (last_at == N - 1);
         @(negedge clk);
         checks++;
         if (err_len !== !ok || busy !== ok || s_ready !== 1'b0 || load_ref_ram !== (ok && m_rd_free)) begin
            errors++;
            $display("FAIL area_end got err=%b busy=%b rdy=%b load=%b want err=%b busy=%b rdy=0 load=%b",
                     err_len, busy, s_ready, load_ref_ram, !ok, ok, ok && m_rd_free);
         end
         m_wait = ok;
         model_swap();
      end
   endtask

   task automatic idle(input int n, input int rel_at);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rd_release = (i == rel_at);
         @(negedge clk);
         checks++;
         if (load_ref_ram !== (m_wait && m_rd_free) || busy !== m_wait || s_ready !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL idle_ctrl i=%0d got load=%b busy=%b rdy=%b err=%b want load=%b busy=%b rdy=0 err=0",
                     i, load_ref_ram, busy, s_ready, err_len, m_wait && m_rd_free, m_wait);
         end
         checks++;
         if (rd_bank !== m_rd_bank || rd_valid !== m_rd_valid || ram_bank !== m_fill) begin
            errors++;
            $display("FAIL idle_banks i=%0d got rd_bank=%b rd_valid=%b fill=%b want %b %b %b",
                     i, rd_bank, rd_valid, ram_bank, m_rd_bank, m_rd_valid, m_fill);
         end
         if (m_wait && m_rd_free) model_swap();
         else if (rd_release && m_rd_valid) m_rd_free = 1'b1;
      end
      rd_release = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b1; s_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b rdy=%b we=%b want 0 0 0", busy, s_ready, ram_we);
      end
      checks++;
      if (rd_bank !== 1'b1 || rd_valid !== 1'b0 || ram_bank !== 1'b0 || ram_waddr !== 9'd0) begin
         errors++;
         $display("FAIL reset_banks got rd_bank=%b rd_valid=%b fill=%b addr=%0d want 1 0 0 0",
                  rd_bank, rd_valid, ram_bank, ram_waddr);
      end
      checks++;
      if (load_ref_ram !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses got load=%b err=%b want 0 0", load_ref_ram, err_len);
      end
      rst = 1'b0; s_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_single_area();
      do_start();
      fill_area(N, N - 1, 3, -1, -1, 1'b1);
      idle(3, -1);
      checks++;
      if (rd_bank !== 1'b0 || rd_valid !== 1'b1 || ram_bank !== 1'b1) begin
         errors++;
         $display("FAIL single_swap got rd_bank=%b rd_valid=%b fill=%b want 0 1 1", rd_bank, rd_valid, ram_bank);
      end
   endtask

   task automatic test_gaps();
      do_start();
      fill_area(N, N - 1, 1, -1, -1, 1'b1);
   endtask

   task automatic test_pingpong();
      idle(15, -1);
      idle(4, 1);
      checks++;
      if (rd_bank !== 1'b1 || rd_valid !== 1'b1 || ram_bank !== 1'b0) begin
         errors++;
         $display("FAIL pingpong_swap got rd_bank=%b rd_valid=%b fill=%b want 1 1 0", rd_bank, rd_valid, ram_bank);
      end
   endtask

   task automatic test_len_err();
      do_start();
      fill_area(101, 100, 2, -1, -1, 1'b1);
      idle(2, -1);
      do_start();
      fill_area(N, -1, 0, -1, -1, 1'b1);
      idle(2, -1);
      checks++;
      if (rd_bank !== 1'b1 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL len_err_banks got rd_bank=%b rd_valid=%b want 1 1", rd_bank, rd_valid);
      end
   endtask

   task automatic test_reset_midfill();
      do_start();
      fill_area(200, -1, 2, -1, -1, 1'b0);
      rst = 1'b1; s_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || ram_we !== 1'b0 || load_ref_ram !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL midfill_ctrl got busy=%b rdy=%b we=%b load=%b err=%b want all 0",
                  busy, s_ready, ram_we, load_ref_ram, err_len);
      end
      checks++;
      if (rd_bank !== 1'b1 || rd_valid !== 1'b0 || ram_bank !== 1'b0 || ram_waddr !== 9'd0) begin
         errors++;
         $display("FAIL midfill_banks got rd_bank=%b rd_valid=%b fill=%b addr=%0d want 1 0 0 0",
                  rd_bank, rd_valid, ram_bank, ram_waddr);
      end
      s_valid = 1'b0;
      model_reset();
      do_start();
      fill_area(N, N - 1, 0, -1, -1, 1'b1);
      idle(2, -1);
      checks++;
      if (rd_bank !== 1'b0 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL midfill_refill got rd_bank=%b rd_valid=%b want 0 1", rd_bank, rd_valid);
      end
   endtask

   task automatic test_ignored();
      do_start();
      fill_area(N, N - 1, 2, 40, -1, 1'b1);
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b0 || load_ref_ram !== 1'b0) begin
         errors++;
         $display("FAIL wait_start got busy=%b rdy=%b load=%b want 1 0 0", busy, s_ready, load_ref_ram);
      end
      idle(8, -1);
      idle(4, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      idle(4, 1);
      do_start();
      fill_area(N, N - 1, 2, -1, -1, 1'b1);
      idle(3, -1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_release = 1'b0;
      model_reset();
      test_reset();
      test_single_area();
      test_gaps();
      test_pingpong();
      test_len_err();
      test_reset_midfill();
      test_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
